// File: rtl/cache_bus_arbiter.sv
// Arbitrates the L1 I-cache (port 0) and D-cache (port 1) onto one system bus with one
// outstanding line transaction at a time and round-robin fairness between the two ports.
module cache_bus_arbiter #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned TAGWIDTH = 13,
  parameter int unsigned BEATS    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          c_reqcyc,
  output logic [1:0]          c_reqack,
  input  logic [WORDSIZE-1:0] c_req [2],
  input  logic [TAGWIDTH-1:0] c_reqtag [2],
  output logic [1:0]          c_respcyc,
  input  logic [1:0]          c_respack,
  output logic [WORDSIZE-1:0] c_resp [2],
  output logic [TAGWIDTH-1:0] c_resptag [2],
  output logic                bus_reqcyc,
  input  logic                bus_reqack,
  output logic [WORDSIZE-1:0] bus_req,
  output logic [TAGWIDTH-1:0] bus_reqtag,
  input  logic                bus_respcyc,
  output logic                bus_respack,
  input  logic [WORDSIZE-1:0] bus_resp,
  input  logic [TAGWIDTH-1:0] bus_resptag
);

  localparam int unsigned CntW    = $clog2(BEATS) + 1;
  localparam int unsigned ReadBit = TAGWIDTH - 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StWdata} state_e;

  state_e              stateQ, stateD;
  logic [CntW-1:0]     beatCntQ, beatCntD;
  logic                ownerQ, ownerD;
  logic                ownerValidQ, ownerValidD;
  logic                lastGrantQ, lastGrantD;
  logic [1:0]          reqAckQ, reqAckD;
  logic                busReqCycQ, busReqCycD;
  logic [WORDSIZE-1:0] busReqQ, busReqD;
  logic [TAGWIDTH-1:0] busTagQ, busTagD;
  logic                grantSel;
  logic                lastBeat;

  // On a tie the port that did not win last time gets the bus.
  assign grantSel = (c_reqcyc == 2'b11) ? ~lastGrantQ : c_reqcyc[1];
  assign lastBeat = (beatCntQ == LastCnt);

  always_comb begin
    stateD      = stateQ;
    beatCntD    = beatCntQ;
    ownerD      = ownerQ;
    ownerValidD = ownerValidQ;
    lastGrantD  = lastGrantQ;
    reqAckD     = 2'b00;
    busReqCycD  = busReqCycQ;
    busReqD     = busReqQ;
    busTagD     = busTagQ;
    unique case (stateQ)
      StIdle: begin
        if (|c_reqcyc) begin
          stateD      = StReq;
          ownerD      = grantSel;
          ownerValidD = 1'b1;
          lastGrantD  = grantSel;
          reqAckD     = grantSel ? 2'b10 : 2'b01;
          busReqCycD  = 1'b1;
          busReqD     = c_req[grantSel];
          busTagD     = c_reqtag[grantSel];
        end
      end
      StReq: begin
        if (bus_reqack) begin
          busReqCycD = 1'b0;
          beatCntD   = '0;
          stateD     = busTagQ[ReadBit] ? StResp : StWdata;
        end
      end
      StResp, StWdata: begin
        // Read beats arrive on bus_respcyc; write beats are consumed on bus_reqack.
        if ((stateQ == StResp) ? bus_respcyc : bus_reqack) begin
          if (lastBeat) begin
            stateD      = StIdle;
            beatCntD    = '0;
            ownerD      = 1'b0;
            ownerValidD = 1'b0;
          end else begin
            beatCntD = beatCntQ + CntW'(1);
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ      <= StIdle;
      beatCntQ    <= '0;
      ownerQ      <= 1'b0;
      ownerValidQ <= 1'b0;
      lastGrantQ  <= 1'b1;
      reqAckQ     <= 2'b00;
      busReqCycQ  <= 1'b0;
      busReqQ     <= '0;
      busTagQ     <= '0;
    end else begin
      stateQ      <= stateD;
      beatCntQ    <= beatCntD;
      ownerQ      <= ownerD;
      ownerValidQ <= ownerValidD;
      lastGrantQ  <= lastGrantD;
      reqAckQ     <= reqAckD;
      busReqCycQ  <= busReqCycD;
      busReqQ     <= busReqD;
      busTagQ     <= busTagD;
    end
  end

  always_comb begin
    c_reqack     = reqAckQ;
    c_respcyc    = 2'b00;
    c_resp[0]    = '0;
    c_resp[1]    = '0;
    c_resptag[0] = '0;
    c_resptag[1] = '0;
    bus_reqcyc   = busReqCycQ;
    bus_req      = busReqQ;
    bus_reqtag   = busTagQ;
    bus_respack  = ownerValidQ & c_respack[ownerQ];
    if (stateQ == StResp) begin
      c_respcyc[ownerQ] = bus_respcyc;
      c_resp[ownerQ]    = bus_resp;
      c_resptag[ownerQ] = bus_resptag;
    end
    if (stateQ == StWdata) begin
      // Write data streams straight from the owner; its ack mirrors the bus ack per beat.
      bus_reqcyc        = 1'b1;
      bus_req           = c_req[ownerQ];
      c_reqack[ownerQ]  = bus_reqack;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: vector table for a single read, directed corner
// sequences, then randomized traffic checked against a transaction-level model.
module tb_cache_bus_arbiter;

  localparam int W = 64;
  localparam int T = 13;
  localparam int B = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    c_reqcyc, c_reqack, c_respcyc, c_respack;
  logic [W-1:0]  c_req [2];
  logic [W-1:0]  c_resp [2];
  logic [T-1:0]  c_reqtag [2];
  logic [T-1:0]  c_resptag [2];
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [W-1:0]  bus_req, bus_resp;
  logic [T-1:0]  bus_reqtag, bus_resptag;

  int nTests = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.WORDSIZE(W), .TAGWIDTH(T), .BEATS(B)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_reqcyc(c_reqcyc), .c_reqack(c_reqack), .c_req(c_req), .c_reqtag(c_reqtag),
    .c_respcyc(c_respcyc), .c_respack(c_respack), .c_resp(c_resp), .c_resptag(c_resptag),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  typedef struct {
    logic [1:0]  reqcyc;
    logic        bReqack;
    logic        bRespcyc;
    logic [63:0] bResp;
    logic [1:0]  xReqack;
    logic        xBreqcyc;
    logic [63:0] xBreq;
    logic [1:0]  xRespcyc;
    logic [63:0] xResp0;
    logic        xRespack;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(logic [1:0] rc, logic ra, logic rs, logic [63:0] rd,
                              logic [1:0] xa, logic xc, logic [63:0] xq, logic [1:0] xr,
                              logic [63:0] x0, logic xk);
    vec_t v;
    v.reqcyc = rc; v.bReqack = ra; v.bRespcyc = rs; v.bResp = rd;
    v.xReqack = xa; v.xBreqcyc = xc; v.xBreq = xq; v.xRespcyc = xr; v.xResp0 = x0;
    v.xRespack = xk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    c_reqcyc = 2'b00; c_respack = 2'b00;
    c_req[0] = '0; c_req[1] = '0; c_reqtag[0] = '0; c_reqtag[1] = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
  endtask

  // Randomized-phase model state
  typedef enum int {PhAddr, PhRead, PhWrite} ph_e;
  bit          pend [2];
  bit          isRd [2];
  logic [63:0] pAddr [2];
  logic [T-1:0] pTag [2];
  logic [63:0] wData [2][B];
  bit          busy, own, lastG, first;
  ph_e         phase;
  int          beats, nDone;
  int          gapPat [11] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clearIn();
    reset_n = 1'b0;
    step(); step();
    chk("reset c_reqack", c_reqack, 2'b00);
    chk("reset bus_reqcyc", bus_reqcyc, 1'b0);
    chk("reset bus_req", bus_req, 64'h0);
    chk("reset bus_reqtag", bus_reqtag, 13'h0);
    chk("reset c_respcyc", c_respcyc, 2'b00);
    chk("reset bus_respack", bus_respack, 1'b0);
    chk("reset c_resp0", c_resp[0], 64'h0);
    reset_n = 1'b1;

    // Single I-cache read of 0x1000, eight beats 0xA0..0xA7, then a stray beat.
    vecs[0] = mk(2'b01, 0, 0, 64'h0, 2'b00, 0, 64'h0, 2'b00, 64'h0, 0);
    vecs[1] = mk(2'b00, 1, 0, 64'h0, 2'b01, 1, 64'h1000, 2'b00, 64'h0, 1);
    for (int k = 2; k < 10; k++)
      vecs[k] = mk(2'b00, 0, 1, 64'hA0 + 64'(k - 2), 2'b00, 0, 64'h0, 2'b01,
                   64'hA0 + 64'(k - 2), 1);
    vecs[10] = mk(2'b00, 0, 1, 64'hFF, 2'b00, 0, 64'h0, 2'b00, 64'h0, 0);
    c_req[0] = 64'h1000; c_reqtag[0] = 13'h1ABC; c_respack = 2'b01;
    for (int k = 0; k < 11; k++) begin
      c_reqcyc = vecs[k].reqcyc; bus_reqack = vecs[k].bReqack;
      bus_respcyc = vecs[k].bRespcyc; bus_resp = vecs[k].bResp;
      #1;
      chk($sformatf("vec%0d c_reqack", k), c_reqack, vecs[k].xReqack);
      chk($sformatf("vec%0d bus_reqcyc", k), bus_reqcyc, vecs[k].xBreqcyc);
      if (vecs[k].xBreqcyc) chk($sformatf("vec%0d bus_req", k), bus_req, vecs[k].xBreq);
      chk($sformatf("vec%0d c_respcyc", k), c_respcyc, vecs[k].xRespcyc);
      chk($sformatf("vec%0d c_resp0", k), c_resp[0], vecs[k].xResp0);
      chk($sformatf("vec%0d bus_respack", k), bus_respack, vecs[k].xRespack);
      step();
    end
    bus_respcyc = 1'b0;

    // D-cache read whose bus ack is held off for five cycles, then gapped response beats.
    c_respack = 2'b11; c_reqcyc = 2'b10; c_req[1] = 64'h3000; c_reqtag[1] = 13'h1123;
    step();
    c_reqcyc = 2'b00; bus_reqack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 0) chk("dly c_reqack", c_reqack, 2'b10);
      chk($sformatf("dly%0d bus_reqcyc", i), bus_reqcyc, 1'b1);
      chk($sformatf("dly%0d bus_req", i), bus_req, 64'h3000);
      chk($sformatf("dly%0d bus_reqtag", i), bus_reqtag, 13'h1123);
      step();
    end
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    #1;
    chk("dly bus_reqcyc drop", bus_reqcyc, 1'b0);
    for (int i = 0; i < 11; i++) begin
      bus_respcyc = (gapPat[i] != 0); bus_resp = 64'hB0 + 64'(i);
      #1;
      chk($sformatf("gap%0d c_respcyc", i), c_respcyc, (gapPat[i] != 0) ? 2'b10 : 2'b00);
      if (gapPat[i] != 0) chk($sformatf("gap%0d c_resp1", i), c_resp[1], 64'hB0 + 64'(i));
      step();
    end
    bus_respcyc = 1'b1;
    #1;
    chk("gap released c_respcyc", c_respcyc, 2'b00);
    chk("gap released bus_respack", bus_respack, 1'b0);
    bus_respcyc = 1'b0;
    step();

    // Reset in the middle of a read, then a fresh D-cache grant with stale beats present.
    c_reqcyc = 2'b01; c_req[0] = 64'h4000; c_reqtag[0] = 13'h1000;
    step();
    c_reqcyc = 2'b00; bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hC0 + 64'(i);
      step();
    end
    #1;
    chk("mid-read c_respcyc", c_respcyc, 2'b01);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort c_respcyc", c_respcyc, 2'b00);
    chk("abort c_resp0", c_resp[0], 64'h0);
    chk("abort bus_respack", bus_respack, 1'b0);
    chk("abort bus_reqcyc", bus_reqcyc, 1'b0);
    chk("abort c_reqack", c_reqack, 2'b00);
    step();
    reset_n = 1'b1;
    #1;
    chk("stale c_respcyc", c_respcyc, 2'b00);
    chk("stale bus_respack", bus_respack, 1'b0);
    c_reqcyc = 2'b10; c_req[1] = 64'h5000; c_reqtag[1] = 13'h0456;
    step();
    c_reqcyc = 2'b00; bus_respcyc = 1'b0;
    #1;
    chk("post-reset c_reqack", c_reqack, 2'b10);
    chk("post-reset bus_reqcyc", bus_reqcyc, 1'b1);
    chk("post-reset bus_req", bus_req, 64'h5000);

    // Randomized traffic against a transaction-level model.
    clearIn();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    busy = 0; lastG = 1; first = 0; own = 0; beats = 0; nDone = 0; phase = PhAddr;
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && !(busy && own == p) && $urandom_range(0, 3) == 0) begin
          pend[p] = 1;
          isRd[p] = bit'($urandom_range(0, 1));
          pAddr[p] = {$urandom, $urandom};
          pTag[p] = {isRd[p], 12'($urandom)};
          for (int b = 0; b < B; b++) wData[p][b] = {$urandom, $urandom};
        end
        c_reqcyc[p] = pend[p];
        c_req[p] = (busy && own == p && phase == PhWrite) ? wData[p][beats] : pAddr[p];
        c_reqtag[p] = pTag[p];
      end
      c_respack = 2'($urandom);
      bus_reqack = bit'($urandom_range(0, 1));
      bus_respcyc = (!busy || phase == PhRead) ? bit'($urandom_range(0, 1)) : 1'b0;
      bus_resp = {$urandom, $urandom};
      bus_resptag = 13'($urandom);
      #1;
      if (!busy) begin
        chk("rnd idle c_reqack", c_reqack, 2'b00);
        chk("rnd idle bus_reqcyc", bus_reqcyc, 1'b0);
        chk("rnd idle c_respcyc", c_respcyc, 2'b00);
        chk("rnd idle bus_respack", bus_respack, 1'b0);
      end else begin
        case (phase)
          PhAddr: begin
            chk("rnd addr bus_reqcyc", bus_reqcyc, 1'b1);
            chk("rnd addr bus_req", bus_req, pAddr[own]);
            chk("rnd addr bus_reqtag", bus_reqtag, pTag[own]);
            chk("rnd addr c_reqack", c_reqack, first ? (own ? 2'b10 : 2'b01) : 2'b00);
            chk("rnd addr c_respcyc", c_respcyc, 2'b00);
          end
          PhRead: begin
            chk("rnd read c_respcyc", c_respcyc,
                bus_respcyc ? (own ? 2'b10 : 2'b01) : 2'b00);
            if (bus_respcyc) begin
              chk("rnd read c_resp", c_resp[own], bus_resp);
              chk("rnd read c_resptag", c_resptag[own], bus_resptag);
            end
            chk("rnd read other c_resp", c_resp[!own], 64'h0);
            chk("rnd read bus_respack", bus_respack, c_respack[own]);
            chk("rnd read bus_reqcyc", bus_reqcyc, 1'b0);
          end
          default: begin
            chk("rnd write bus_reqcyc", bus_reqcyc, 1'b1);
            chk("rnd write bus_req", bus_req, wData[own][beats]);
            chk("rnd write c_reqack", c_reqack,
                bus_reqack ? (own ? 2'b10 : 2'b01) : 2'b00);
            chk("rnd write c_respcyc", c_respcyc, 2'b00);
          end
        endcase
      end
      // What the coming clock edge does at transaction level.
      if (!busy) begin
        if (pend[0] || pend[1]) begin
          own = (pend[0] && pend[1]) ? !lastG : pend[1];
          lastG = own; busy = 1; phase = PhAddr; first = 1; pend[own] = 0;
        end
      end else begin
        case (phase)
          PhAddr: begin
            first = 0;
            if (bus_reqack) begin
              phase = isRd[own] ? PhRead : PhWrite;
              beats = 0;
            end
          end
          PhRead: if (bus_respcyc) beats++;
          default: if (bus_reqack) beats++;
        endcase
        if (phase != PhAddr && beats == B) begin
          busy = 0; beats = 0; nDone++;
        end
      end
      step();
    end
    chk("rnd transactions completed", nDone >= 50, 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
